// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: word-wide array with byte enables, fixed access latency, ramReady handshake.
// Optional DMEM_PERF_CNT_EN adds stall-cycle and completed-access counters.
module data_mem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writeData,
    input  logic        i_memAdvance,
    output logic        o_ramReady,
    output logic [31:0] o_readData,
    output logic        o_misaligned
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] o_stallCycles,
    output logic [31:0] o_accessCount
`endif
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CTR_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_ctr;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [31:0]       r_wdata;
    logic              r_isStore;
    logic [31:0]       r_readData;
    logic              r_misaligned;
    logic [31:0]       r_mem [DEPTH];

    logic              w_req;
    logic              w_fault;
    logic              w_isIdle;
    logic              w_isWait;
    logic              w_isDone;
    logic              w_accept;
    logic              w_finish;
    logic [ADDR_W-3:0] w_wordIdx;
    logic [31:0]       w_rdWord;
    logic [31:0]       w_shifted;
    logic [31:0]       w_loadData;
    logic [31:0]       w_wdataLanes;
    logic [3:0]        w_byteEn;
    logic              w_unusedAddr;

    assign w_unusedAddr = ^i_addr[31:ADDR_W];

    // The unused 2'b11 encoding falls into the IDLE decode so it recovers on the next request.
    assign w_isWait = (r_state == WAIT);
    assign w_isDone = (r_state == DONE);
    assign w_isIdle = ~w_isWait & ~w_isDone;
    assign w_req    = i_memRead | i_memWrite;
    assign w_accept = w_isIdle & w_req & ~w_fault;
    assign w_finish = w_isWait & (r_ctr == 4'd0);

    assign o_ramReady   = w_isDone | (w_isIdle & (~w_req | w_fault));
    assign o_readData   = r_readData;
    assign o_misaligned = r_misaligned;

    always_comb begin
        w_fault = 1'b0;
        case (i_funct3)
            3'b001, 3'b101:         w_fault = i_addr[0];
            3'b010:                 w_fault = (i_addr[1:0] != 2'b00);
            3'b011, 3'b110, 3'b111: w_fault = 1'b1;
            default:                w_fault = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            WAIT:    if (r_ctr == 4'd0) w_nextState = DONE;
            DONE:    if (i_memAdvance)  w_nextState = IDLE;
            default: w_nextState = w_accept ? WAIT : IDLE;
        endcase
    end

    assign w_wordIdx = r_addr[ADDR_W-1:2];
    assign w_rdWord  = r_mem[w_wordIdx];
    assign w_shifted = w_rdWord >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_loadData = w_rdWord;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_loadData = {24'd0, w_shifted[7:0]};
            3'b101:  w_loadData = {16'd0, w_shifted[15:0]};
            default: w_loadData = w_rdWord;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select the target bytes.
    always_comb begin
        w_byteEn     = 4'b1111;
        w_wdataLanes = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_byteEn     = 4'b0001 << r_addr[1:0];
                w_wdataLanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_byteEn     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdataLanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_byteEn     = 4'b1111;
                w_wdataLanes = r_wdata;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_finish && r_isStore) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) r_mem[w_wordIdx][b*8 +: 8] <= w_wdataLanes[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctr        <= 4'd0;
            r_addr       <= '0;
            r_funct3     <= 3'd0;
            r_wdata      <= 32'd0;
            r_isStore    <= 1'b0;
            r_readData   <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_isIdle & w_req & w_fault;
            if (w_isIdle && w_req && w_fault) r_readData <= 32'd0;
            if (w_accept) begin
                r_addr    <= i_addr[ADDR_W-1:0];
                r_funct3  <= i_funct3;
                r_wdata   <= i_writeData;
                r_isStore <= i_memWrite;
                r_ctr     <= CTR_INIT;
            end else if (w_isWait && r_ctr != 4'd0) begin
                r_ctr <= r_ctr - 4'd1;
            end
            if (w_finish && !r_isStore) r_readData <= w_loadData;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_accessCount;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stallCycles <= 32'd0;
            r_accessCount <= 32'd0;
        end else begin
            if (!o_ramReady) r_stallCycles <= r_stallCycles + 32'd1;
            if (w_finish)    r_accessCount <= r_accessCount + 32'd1;
        end
    end

    assign o_stallCycles = r_stallCycles;
    assign o_accessCount = r_accessCount;
`endif

endmodule
